// File: rtl/sim_tb_cmd_arbiter.sv
// Round-robin arbiter that shares one interpreter command channel among NREQ requesters,
// tracks one outstanding command at a time and answers with a response or a timeout.
module sim_tb_cmd_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               interp_started,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_cmd,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_data,
  output logic               timeout_err,
  output logic               busy,
  output logic               cmd_valid,
  output logic [DW-1:0]      cmd_data,
  input  logic               cmd_ready,
  input  logic               rsp_valid,
  input  logic [DW-1:0]      rsp_in
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {WAIT_START, IDLE, ISSUE, WAIT_RSP} state_t;

  state_t                   state;
  logic [IW-1:0]            last_winner, winner, pick, idx;
  logic [TW-1:0]            timer;
  logic [NREQ-1:0][DW-1:0]  cmds;

  assign cmds = req_cmd;
  assign busy = (state == ISSUE) || (state == WAIT_RSP);

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Scan from farthest to nearest so the requester closest after last_winner is left in pick.
  always_comb begin
    pick = last_winner;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_winner) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= WAIT_START;
      gnt         <= '0;
      done        <= '0;
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
      timer       <= '0;
      winner      <= '0;
      last_winner <= IW'(NREQ - 1);
    end else begin
      done <= '0;
      if (!interp_started) begin
        // Abort without crediting the winner so it is granted again after restart.
        gnt       <= '0;
        cmd_valid <= 1'b0;
        timer     <= '0;
        state     <= WAIT_START;
      end else begin
        case (state)
          WAIT_START: state <= IDLE;
          IDLE: if (|req) begin
            winner    <= pick;
            gnt       <= onehot(pick);
            cmd_data  <= cmds[pick];
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end
          ISSUE: if (cmd_ready) begin
            cmd_valid <= 1'b0;
            timer     <= '0;
            state     <= WAIT_RSP;
          end
          WAIT_RSP: begin
            if (rsp_valid || timer == TW'(TIMEOUT - 1)) begin
              rsp_data    <= rsp_valid ? rsp_in : '1;
              timeout_err <= timeout_err | ~rsp_valid;
              done        <= onehot(winner);
              gnt         <= '0;
              last_winner <= winner;
              state       <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: state <= WAIT_START;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sim_tb_cmd_arbiter.sv
// Bench for sim_tb_cmd_arbiter: transaction table, directed corner sequences,
// then randomized cycles against a transaction-level reference model.
module tb_sim_tb_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TO   = 8;

  logic               CLK = 1'b0;
  logic               RST;
  logic               interp_started;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_cmd;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      rsp_data, cmd_data, rsp_in;
  logic               timeout_err, busy, cmd_valid, cmd_ready, rsp_valid;

  sim_tb_cmd_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .interp_started(interp_started), .req(req), .req_cmd(req_cmd),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .timeout_err(timeout_err), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_in(rsp_in)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [DW-1:0]   rsp;
    int              idx;
  } txn_t;
  txn_t tbl[10];

  // Reference model: who owns the channel, whether the command was taken, cycles waited.
  bit          m_up, m_acc, m_cv, m_err;
  int          m_own, m_wait, m_last, m_done;
  logic [DW-1:0] m_cmd, m_rsp;

  task automatic model_edge();
    if (RST) begin
      m_up = 0; m_own = -1; m_acc = 0; m_cv = 0; m_cmd = '0; m_rsp = '0;
      m_err = 0; m_wait = 0; m_last = NREQ - 1; m_done = -1;
    end else begin
      m_done = -1;
      if (!interp_started) begin
        m_up = 0; m_own = -1; m_acc = 0; m_cv = 0; m_wait = 0;
      end else if (!m_up) begin
        m_up = 1;
      end else if (m_own < 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (m_own < 0 && req[(m_last + k) % NREQ]) m_own = (m_last + k) % NREQ;
        if (m_own >= 0) begin
          m_cmd = req_cmd[m_own*DW +: DW]; m_cv = 1; m_acc = 0;
        end
      end else if (!m_acc) begin
        if (cmd_ready) begin m_acc = 1; m_cv = 0; m_wait = 0; end
      end else if (rsp_valid || m_wait == TO - 1) begin
        m_rsp = rsp_valid ? rsp_in : '1;
        if (!rsp_valid) m_err = 1;
        m_done = m_own; m_last = m_own; m_own = -1; m_acc = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [63:0] oh(input int i);
    return (i >= 0) ? (64'd1 << i) : 64'd0;
  endfunction

  initial begin
    tbl[0] = '{4'b1111, 32'h11, 0};
    tbl[1] = '{4'b1111, 32'h22, 1};
    tbl[2] = '{4'b1111, 32'h33, 2};
    tbl[3] = '{4'b1111, 32'h44, 3};
    tbl[4] = '{4'b1111, 32'h55, 0};
    tbl[5] = '{4'b1010, 32'h66, 1};
    tbl[6] = '{4'b1010, 32'h77, 3};
    tbl[7] = '{4'b0001, 32'h88, 0};
    tbl[8] = '{4'b0110, 32'h99, 1};
    tbl[9] = '{4'b1001, 32'hAA, 3};

    req_cmd = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    RST = 1; interp_started = 0; req = '0; cmd_ready = 0; rsp_valid = 0; rsp_in = '0;
    step();
    chk("rst_gnt", gnt, 0); chk("rst_cv", cmd_valid, 0); chk("rst_err", timeout_err, 0);
    chk("rst_busy", busy, 0); chk("rst_cmd", cmd_data, 0);

    // Requests while the interpreter is down are never granted.
    RST = 0; req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("nostart_gnt", gnt, 0); chk("nostart_cv", cmd_valid, 0);
    end
    interp_started = 1;
    step(); chk("start_e1_gnt", gnt, 0);
    step(); chk("start_e2_gnt", gnt, 4'b0001); chk("start_e2_cv", cmd_valid, 1);

    // Reset while a command is issued discards it.
    RST = 1; step(); RST = 0;
    chk("rstiss_gnt", gnt, 0); chk("rstiss_cv", cmd_valid, 0); chk("rstiss_done", done, 0);
    chk("rstiss_cmd", cmd_data, 0); chk("rstiss_busy", busy, 0);
    req = '0; step();

    foreach (tbl[i]) begin
      req = tbl[i].req; step();
      chk("tbl_gnt", gnt, oh(tbl[i].idx)); chk("tbl_cv", cmd_valid, 1);
      chk("tbl_cmd", cmd_data, req_cmd[tbl[i].idx*DW +: DW]);
      cmd_ready = 1; step(); cmd_ready = 0;
      chk("tbl_acc_cv", cmd_valid, 0);
      rsp_valid = 1; rsp_in = tbl[i].rsp; step(); rsp_valid = 0;
      chk("tbl_done", done, oh(tbl[i].idx)); chk("tbl_rsp", rsp_data, tbl[i].rsp);
      chk("tbl_gnt_clr", gnt, 0);
    end

    // Stalled issue: command held even if the source changes, early responses ignored.
    req = 4'b0100; step();
    chk("stall_gnt", gnt, 4'b0100);
    req = '0; req_cmd[2*DW +: DW] = 32'hEEEE_EEEE;
    for (int c = 0; c < 5; c++) begin
      rsp_valid = (c == 2); rsp_in = 32'hBAD0_0BAD; step();
      chk("stall_cv", cmd_valid, 1); chk("stall_cmd", cmd_data, 32'hC2C2_0002);
      chk("stall_done", done, 0);
    end
    req_cmd[2*DW +: DW] = 32'hC2C2_0002;
    cmd_ready = 1; rsp_valid = 1; step(); cmd_ready = 0; rsp_valid = 0;
    chk("acc_same_rsp_done", done, 0); chk("acc_cv", cmd_valid, 0);
    step(); chk("wait_done", done, 0);
    rsp_valid = 1; rsp_in = 32'h1234_5678; step(); rsp_valid = 0;
    chk("dropreq_done", done, 4'b0100); chk("dropreq_rsp", rsp_data, 32'h1234_5678);

    // Response on the would-be timeout cycle is a normal completion.
    req = 4'b1000; step(); req = '0;
    cmd_ready = 1; step(); cmd_ready = 0;
    for (int c = 0; c < TO - 1; c++) begin step(); chk("late_done", done, 0); end
    rsp_valid = 1; rsp_in = 32'h27; step(); rsp_valid = 0;
    chk("late_done_hit", done, 4'b1000); chk("late_rsp", rsp_data, 32'h27);
    chk("late_err", timeout_err, 0);

    // No response at all: timeout completion.
    req = 4'b0001; step(); req = '0;
    cmd_ready = 1; step(); cmd_ready = 0;
    for (int c = 0; c < TO - 1; c++) begin
      step(); chk("to_wait_done", done, 0); chk("to_wait_busy", busy, 1);
    end
    step();
    chk("to_done", done, 4'b0001); chk("to_rsp", rsp_data, 32'hFFFF_FFFF);
    chk("to_err", timeout_err, 1); chk("to_busy", busy, 0);

    // Interpreter drops during WAIT_RSP: abort, same requester is re-granted on restart.
    req = 4'b0010; step(); chk("abort_gnt", gnt, 4'b0010);
    cmd_ready = 1; step(); cmd_ready = 0; req = '0;
    step();
    interp_started = 0; step();
    chk("abort_gnt0", gnt, 0); chk("abort_cv", cmd_valid, 0);
    chk("abort_done", done, 0); chk("abort_busy", busy, 0);
    step(); chk("abort_done2", done, 0);
    interp_started = 1; req = 4'b1111;
    step(); chk("restart_e1", gnt, 0);
    step(); chk("restart_gnt", gnt, 4'b0010); chk("sticky_err", timeout_err, 1);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      RST = (i == 0) || ($urandom_range(0, 299) == 0);
      interp_started = ($urandom_range(0, 39) != 0);
      req = NREQ'($urandom);
      cmd_ready = $urandom_range(0, 1);
      rsp_valid = ($urandom_range(0, 9) < 3);
      rsp_in = $urandom;
      req_cmd = {$urandom, $urandom, $urandom, $urandom};
      model_edge();
      step();
      chk("rnd_gnt", gnt, oh(m_own)); chk("rnd_done", done, oh(m_done));
      chk("rnd_cv", cmd_valid, m_cv); chk("rnd_cmd", cmd_data, m_cmd);
      chk("rnd_err", timeout_err, m_err); chk("rnd_busy", busy, m_own >= 0);
      if (m_done >= 0) chk("rnd_rsp", rsp_data, m_rsp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
